intr_ack_sequencer: RTL and testbench

- Processor-side partner of the polled interrupt controller.
- Answers the controller's three-step handshake (interrupt acknowledge, ID acknowledge, ISR-done report) on `intr_in`/`intr_bus`.
- Hands each captured source ID to local ISR logic and waits for its completion.
- Sits between the interrupt controller and the execution/ISR datapath.

---
 rtl/intr_pkg.sv | 32 +++
 rtl/intr_timeout_counter.sv | 28 ++
 rtl/intr_ack_sequencer.sv | 148 ++++++++++++++
 tb/tb_intr_ack_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Handshake definitions shared by the interrupt acknowledge sequencer and the
// polled interrupt controller: state encoding, bus code words, error codes.
package intr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ACK_IRQ  = 3'd1,
      ST_WAIT_ID  = 3'd2,
      ST_ACK_ID   = 3'd3,
      ST_REL_WAIT = 3'd4,
      ST_SERVICE  = 3'd5,
      ST_DONE     = 3'd6,
      ST_ERR      = 3'd7
   } intr_state_t;

   // Upper five bits of every word on intr_bus identify who is talking.
   localparam logic [4:0] INTR_CODE_ID   = 5'b01011;
   localparam logic [4:0] INTR_CODE_DONE = 5'b10100;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_NO_ID  = 2'b01;
   localparam logic [1:0] ERR_ISR_TO = 2'b10;

   function automatic logic is_id_word(input logic [7:0] word);
      return (word[7:3] == INTR_CODE_ID);
   endfunction

   function automatic logic [7:0] done_word(input logic [2:0] id);
      return {INTR_CODE_DONE, id};
   endfunction

endpackage

// File: rtl/intr_timeout_counter.sv
// Wait-time counter for the acknowledge sequencer: counts enabled cycles and
// flags the cycle on which the count reaches LIMIT.
module intr_timeout_counter #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // High on the cycle whose increment brings the count to LIMIT.
   assign expired = enable && !clear && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/intr_ack_sequencer.sv
// Processor-side partner of the polled interrupt controller: acknowledges the
// request, captures the source ID, runs the ISR and reports completion.
// Optional wait timeouts are built when INTR_SEQ_TIMEOUT_EN is defined.
module intr_ack_sequencer
   import intr_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned REL_GUARD      = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        intr_req,
   output logic        intr_ack,
   inout  wire  [7:0]  intr_bus,
   output logic        bus_oe,
   output logic        isr_start,
   output logic [2:0]  isr_id,
   input  logic        isr_done,
   output logic        busy,
   output logic        err,
   output logic [1:0]  err_code,
   output intr_state_t state_dbg
);

   localparam int unsigned REL_W = (REL_GUARD > 1) ? $clog2(REL_GUARD) : 1;

   intr_state_t      state;
   logic [REL_W-1:0] rel_cnt;
   logic [7:0]       bus_q;

`ifdef INTR_SEQ_TIMEOUT_EN
   logic to_count_en;
   logic to_expired;

   assign to_count_en = (state == ST_WAIT_ID) || (state == ST_SERVICE);

   intr_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clear   (!to_count_en),
      .enable  (to_count_en),
      .expired (to_expired)
   );
`endif

   // Handshake: intr_ack is low for exactly one cycle per step (request taken,
   // ID taken, ISR done); the DONE report drives intr_bus in that same cycle,
   // and intr_bus is driven only while bus_oe=1, otherwise left high-Z.
   assign intr_bus  = bus_oe ? bus_q : 8'bz;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         intr_ack  <= 1'b1;
         bus_oe    <= 1'b0;
         bus_q     <= '0;
         isr_start <= 1'b0;
         isr_id    <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
         rel_cnt   <= '0;
      end else begin
         isr_start <= 1'b0;
         err       <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (intr_req) begin
                  state    <= ST_ACK_IRQ;
                  intr_ack <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ST_ACK_IRQ: begin
               state    <= ST_WAIT_ID;
               intr_ack <= 1'b1;
            end
            ST_WAIT_ID: begin
               if (is_id_word(intr_bus)) begin
                  state    <= ST_ACK_ID;
                  intr_ack <= 1'b0;
                  isr_id   <= intr_bus[2:0];
               end
`ifdef INTR_SEQ_TIMEOUT_EN
               else if (to_expired) begin
                  state    <= ST_ERR;
                  err      <= 1'b1;
                  err_code <= ERR_NO_ID;
               end
`endif
            end
            ST_ACK_ID: begin
               state    <= ST_REL_WAIT;
               intr_ack <= 1'b1;
               rel_cnt  <= REL_W'(REL_GUARD - 1);
            end
            ST_REL_WAIT: begin
               // The controller may still be driving the ID; hold off the bus.
               if (rel_cnt == '0) begin
                  state     <= ST_SERVICE;
                  isr_start <= 1'b1;
               end else begin
                  rel_cnt <= rel_cnt - 1'b1;
               end
            end
            ST_SERVICE: begin
               // isr_start is high only on the first SERVICE cycle, where
               // isr_done is not yet trusted.
               if (!isr_start && isr_done) begin
                  state    <= ST_DONE;
                  intr_ack <= 1'b0;
                  bus_oe   <= 1'b1;
                  bus_q    <= done_word(isr_id);
               end
`ifdef INTR_SEQ_TIMEOUT_EN
               else if (to_expired) begin
                  state    <= ST_ERR;
                  err      <= 1'b1;
                  err_code <= ERR_ISR_TO;
               end
`endif
            end
            ST_DONE: begin
               state    <= ST_IDLE;
               intr_ack <= 1'b1;
               bus_oe   <= 1'b0;
               busy     <= 1'b0;
            end
            ST_ERR: begin
               state    <= ST_IDLE;
               intr_ack <= 1'b1;
               bus_oe   <= 1'b0;
               busy     <= 1'b0;
            end
            default: begin
               state    <= ST_IDLE;
               intr_ack <= 1'b1;
               bus_oe   <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_intr_ack_sequencer.sv
// Scoreboard bench for intr_ack_sequencer: directed controller transactions,
// expected handshake events queued with their cycle, compared by a monitor.
module tb_intr_ack_sequencer;
   import intr_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk      = 1'b0;
   logic        reset    = 1'b1;
   logic        intr_req = 1'b0;
   logic        isr_done = 1'b0;
   logic        intr_ack;
   logic        bus_oe;
   logic        isr_start;
   logic [2:0]  isr_id;
   logic        busy;
   logic        err;
   logic [1:0]  err_code;
   intr_state_t state_dbg;
   wire  [7:0]  intr_bus;
   logic [7:0]  ctl_data = 8'h00;
   logic        ctl_oe   = 1'b0;

   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;
   logic [27:0] exp_q[$];
   logic [27:0] obs;
   logic [27:0] exp_ev;
   logic [7:0]  obs_data;

   assign intr_bus = ctl_oe ? ctl_data : 8'bz;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   intr_ack_sequencer #(
      .TIMEOUT_CYCLES (8),
      .REL_GUARD      (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .intr_req  (intr_req),
      .intr_ack  (intr_ack),
      .intr_bus  (intr_bus),
      .bus_oe    (bus_oe),
      .isr_start (isr_start),
      .isr_id    (isr_id),
      .isr_done  (isr_done),
      .busy      (busy),
      .err       (err),
      .err_code  (err_code),
      .state_dbg (state_dbg)
   );

   // ---------------- driver helpers ----------------
   // Event word: {cycle[15:0], intr_ack, bus_oe, isr_start, err, data[7:0]}
   function automatic logic [27:0] ev(input int c, input logic ack, input logic oe,
                                      input logic st, input logic er, input logic [7:0] d);
      return {c[15:0], ack, oe, st, er, d};
   endfunction

   task automatic exp_ack(input int c);
      exp_q.push_back(ev(c, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
   endtask

   task automatic exp_start(input int c, input logic [2:0] id);
      exp_q.push_back(ev(c, 1'b1, 1'b0, 1'b1, 1'b0, {5'b00000, id}));
   endtask

   task automatic exp_done(input int c, input logic [7:0] word);
      exp_q.push_back(ev(c, 1'b0, 1'b1, 1'b0, 1'b0, word));
   endtask

   task automatic exp_err(input int c, input logic [1:0] code);
      exp_q.push_back(ev(c, 1'b1, 1'b0, 1'b0, 1'b1, {6'b000000, code}));
   endtask

   // Returns #1 after the rising edge that brings the cycle count to c.
   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Controller model: request, ID one cycle after the first ack, isr_done
   // raised three cycles after isr_start. Returns inside the DONE cycle.
   task automatic std_txn(input logic [7:0] id_word, input logic [2:0] id,
                          input logic [7:0] done_w, output int n);
      n = cyc + 1;
      exp_ack(n);
      exp_ack(n + 2);
      exp_start(n + 5, id);
      exp_done(n + 9, done_w);
      intr_req = 1'b1;
      goto(n);
      intr_req = 1'b0;
      goto(n + 1);
      ctl_data = id_word;
      ctl_oe   = 1'b1;
      goto(n + 3);
      ctl_oe   = 1'b0;
      goto(n + 8);
      isr_done = 1'b1;
      goto(n + 9);
      isr_done = 1'b0;
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (mon_en && (!intr_ack || bus_oe || isr_start || err)) begin
         if (bus_oe)         obs_data = intr_bus;
         else if (isr_start) obs_data = {5'b00000, isr_id};
         else if (err)       obs_data = {6'b000000, err_code};
         else                obs_data = 8'h00;
         obs = ev(cyc, intr_ack, bus_oe, isr_start, err, obs_data);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL event got %h expected none", obs);
         end else begin
            exp_ev = exp_q.pop_front();
            if (obs !== exp_ev) begin
               errors++;
               $display("FAIL event got %h expected %h", obs, exp_ev);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int n2;

      goto(3);
      @(negedge clk);
      chk("reset_intr_ack", {7'd0, intr_ack}, 8'h01);
      chk("reset_bus_oe", {7'd0, bus_oe}, 8'h00);
      chk("reset_isr_start", {7'd0, isr_start}, 8'h00);
      chk("reset_isr_id", {5'd0, isr_id}, 8'h00);
      chk("reset_busy", {7'd0, busy}, 8'h00);
      chk("reset_err", {7'd0, err}, 8'h00);
      chk("reset_err_code", {6'd0, err_code}, 8'h00);
      chk("reset_state", 8'(state_dbg), 8'(ST_IDLE));
      goto(4);
      reset  = 1'b0;
      mon_en = 1'b1;

      // 1: normal transaction, ID 3
      goto(cyc + 2);
      std_txn(8'h5B, 3'd3, 8'hA3, n);
      @(negedge clk);
      chk("t1_busy_in_done", {7'd0, busy}, 8'h01);
      goto(n + 10);
      @(negedge clk);
      chk("t1_busy_after", {7'd0, busy}, 8'h00);
      chk("t1_state_idle", 8'(state_dbg), 8'(ST_IDLE));
      chk("t1_bus_released", {7'd0, bus_oe}, 8'h00);

      // 2: foreign bus values, only 0x5E accepted
      goto(cyc + 2);
      n = cyc + 1;
      exp_ack(n);
      exp_ack(n + 4);
      exp_start(n + 7, 3'd6);
      exp_done(n + 11, 8'hA6);
      intr_req = 1'b1;
      goto(n);
      intr_req = 1'b0;
      goto(n + 1);
      ctl_data = 8'hFF;
      ctl_oe   = 1'b1;
      goto(n + 2);
      ctl_data = 8'h12;
      goto(n + 3);
      ctl_data = 8'h5E;
      goto(n + 5);
      ctl_oe   = 1'b0;
      @(negedge clk);
      chk("t2_isr_id", {5'd0, isr_id}, 8'h06);
      goto(n + 10);
      isr_done = 1'b1;
      goto(n + 11);
      isr_done = 1'b0;
      goto(n + 13);

      // 3: isr_done held high before isr_start
      n = cyc + 1;
      exp_ack(n);
      exp_ack(n + 2);
      exp_start(n + 5, 3'd1);
      exp_done(n + 7, 8'hA1);
      intr_req = 1'b1;
      goto(n);
      intr_req = 1'b0;
      goto(n + 1);
      ctl_data = 8'h59;
      ctl_oe   = 1'b1;
      goto(n + 3);
      ctl_oe   = 1'b0;
      isr_done = 1'b1;
      goto(n + 6);
      @(negedge clk);
      chk("t3_still_service", 8'(state_dbg), 8'(ST_SERVICE));
      goto(n + 7);
      isr_done = 1'b0;
      goto(n + 9);

      // 4: back-to-back, request re-raised during DONE
      std_txn(8'h5A, 3'd2, 8'hA2, n);
      intr_req = 1'b1;
      goto(n + 10);
      @(negedge clk);
      chk("t4_idle_between", 8'(state_dbg), 8'(ST_IDLE));
      chk("t4_busy_between", {7'd0, busy}, 8'h00);
      std_txn(8'h5F, 3'd7, 8'hA7, n2);
      goto(n2 + 11);

      // 5: reset during DONE
      std_txn(8'h5C, 3'd4, 8'hA4, n);
      reset = 1'b1;
      goto(n + 10);
      @(negedge clk);
      chk("t5_bus_oe", {7'd0, bus_oe}, 8'h00);
      chk("t5_intr_ack", {7'd0, intr_ack}, 8'h01);
      chk("t5_busy", {7'd0, busy}, 8'h00);
      chk("t5_err", {7'd0, err}, 8'h00);
      chk("t5_err_code", {6'd0, err_code}, 8'h00);
      chk("t5_state", 8'(state_dbg), 8'(ST_IDLE));
      reset = 1'b0;
      goto(cyc + 2);

`ifdef INTR_SEQ_TIMEOUT_EN
      // 6a: no ID ever supplied
      n = cyc + 1;
      exp_ack(n);
      exp_err(n + 9, 2'b01);
      intr_req = 1'b1;
      goto(n);
      intr_req = 1'b0;
      goto(n + 10);
      @(negedge clk);
      chk("t6a_state", 8'(state_dbg), 8'(ST_IDLE));
      chk("t6a_err_code_held", {6'd0, err_code}, 8'h01);
      chk("t6a_err_pulse_over", {7'd0, err}, 8'h00);

      // 6b: ID supplied, isr_done withheld
      goto(cyc + 2);
      n = cyc + 1;
      exp_ack(n);
      exp_ack(n + 2);
      exp_start(n + 5, 3'd5);
      exp_err(n + 13, 2'b10);
      intr_req = 1'b1;
      goto(n);
      intr_req = 1'b0;
      goto(n + 1);
      ctl_data = 8'h5D;
      ctl_oe   = 1'b1;
      goto(n + 3);
      ctl_oe   = 1'b0;
      goto(n + 14);
      @(negedge clk);
      chk("t6b_state", 8'(state_dbg), 8'(ST_IDLE));
      chk("t6b_err_code", {6'd0, err_code}, 8'h02);
      chk("t6b_bus_oe", {7'd0, bus_oe}, 8'h00);
`endif

      goto(cyc + 4);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL events_missing got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------- watchdog ----------------
   initial begin
      repeat (3000) @(posedge clk);
      errors++;
      $display("FAIL watchdog got cycle %0d expected end before 3000", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
